// File: rtl/uart_rx_deframer.sv
// Frame deframer behind a UART receiver: hunts SYNC/LEN/payload/CSUM frames,
// holds the payload until the XOR checksum verifies, then streams it out.
module uart_rx_deframer #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC           = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_done,
    output logic [7:0] o_out_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_out_last,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_BADLEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        DRAIN
    } stateT;

    stateT            r_state;
    logic             r_rxDoneQ;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_idx;
    logic [LW-1:0]    r_rdIdx;
    logic [7:0]       r_csum;
    logic [TW-1:0]    r_tcnt;
    logic             r_frameOk;
    logic             r_frameErr;
    logic [1:0]       r_errCode;
    logic [7:0]       r_buf [MAX_LEN];

    logic             w_byteEvt;
    logic             w_counting;
    logic             w_timeoutHit;
    logic             w_rdLast;
    logic             w_bufWe;
    logic [AW-1:0]    w_wrAddr;
    logic [AW-1:0]    w_rdAddr;

    // rx_done is a level; only its rising edge is a byte.
    assign w_byteEvt    = i_rx_done & ~r_rxDoneQ;
    assign w_counting   = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CSUM);
    assign w_timeoutHit = w_counting && !w_byteEvt && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_rdLast     = (r_rdIdx == r_len - LW'(1));
    assign w_bufWe      = (r_state == PAYLOAD) && w_byteEvt;
    assign w_wrAddr     = r_idx[AW-1:0];
    assign w_rdAddr     = r_rdIdx[AW-1:0];

    // Payload storage needs no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (w_bufWe) begin
            r_buf[w_wrAddr] <= i_rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rxDoneQ  <= 1'b1;
            r_len      <= '0;
            r_idx      <= '0;
            r_rdIdx    <= '0;
            r_csum     <= '0;
            r_tcnt     <= '0;
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            r_errCode  <= ERR_TIMEOUT;
        end else begin
            r_rxDoneQ  <= i_rx_done;
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            r_tcnt     <= (w_counting && !w_byteEvt) ? r_tcnt + TW'(1) : '0;

            case (r_state)
                IDLE: begin
                    if (w_byteEvt && (i_rx_byte == SYNC)) begin
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    if (w_byteEvt) begin
                        if ((i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN))) begin
                            r_errCode  <= ERR_BADLEN;
                            r_frameErr <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_len   <= i_rx_byte[LW-1:0];
                            r_csum  <= i_rx_byte;
                            r_idx   <= '0;
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_byteEvt) begin
                        r_csum <= r_csum ^ i_rx_byte;
                        r_idx  <= r_idx + LW'(1);
                        if (r_idx == r_len - LW'(1)) begin
                            r_state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (w_byteEvt) begin
                        if (i_rx_byte == r_csum) begin
                            r_frameOk <= 1'b1;
                            r_rdIdx   <= '0;
                            r_state   <= DRAIN;
                        end else begin
                            r_errCode  <= ERR_CSUM;
                            r_frameErr <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (i_out_ready) begin
                        if (w_rdLast) begin
                            r_state <= IDLE;
                        end else begin
                            r_rdIdx <= r_rdIdx + LW'(1);
                        end
                    end
                    // The receiver cannot be stalled, so a byte arriving now is lost.
                    if (w_byteEvt) begin
                        r_errCode  <= ERR_OVERRUN;
                        r_frameErr <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_timeoutHit) begin
                r_errCode  <= ERR_TIMEOUT;
                r_frameErr <= 1'b1;
                r_state    <= IDLE;
            end
        end
    end

    assign o_out_valid = (r_state == DRAIN);
    assign o_out_last  = (r_state == DRAIN) && w_rdLast;
    assign o_out_data  = (r_state == DRAIN) ? r_buf[w_rdAddr] : 8'h00;
    assign o_busy      = (r_state != IDLE);
    assign o_frame_ok  = r_frameOk;
    assign o_frame_err = r_frameErr;
    assign o_err_code  = r_errCode;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer; expected bytes and frame events
// are queued as frames are sent and consumed by a monitor.
module tb_uart_rx_deframer;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 20000;
    localparam int         EV_OK   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxByte;
    logic       rxDone;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic       outLast;
    logic       frameOk;
    logic       frameErr;
    logic [1:0] errCode;
    logic       busy;

    int         nErrors = 0;
    int         nChecks = 0;
    logic [8:0] byteQ [$];
    int         evQ [$];
    logic [7:0] frameBytes [$];
    logic [7:0] lastCsum;

    uart_rx_deframer #(
        .MAX_LEN        (MAX_LEN),
        .SYNC           (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_byte   (rxByte),
        .i_rx_done   (rxDone),
        .o_out_data  (outData),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_last  (outLast),
        .o_frame_ok  (frameOk),
        .o_frame_err (frameErr),
        .o_err_code  (errCode),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int hold);
        rxByte = b;
        rxDone = 1'b1;
        waitCycles(hold);
        rxDone = 1'b0;
        waitCycles(2);
    endtask

    // Queues the expected payload and OK event for frameBytes, then sends it.
    task automatic sendFrame(input int hold, input bit withSync, input bit withCsum);
        logic [7:0] cs;
        logic       lastFlag;
        cs = 8'(frameBytes.size());
        for (int i = 0; i < frameBytes.size(); i++) begin
            cs = cs ^ frameBytes[i];
            lastFlag = (i == frameBytes.size() - 1);
            byteQ.push_back({lastFlag, frameBytes[i]});
        end
        evQ.push_back(EV_OK);
        lastCsum = cs;
        if (withSync) applyStimulus(SYNC, hold);
        applyStimulus(8'(frameBytes.size()), hold);
        for (int i = 0; i < frameBytes.size(); i++) applyStimulus(frameBytes[i], hold);
        if (withCsum) applyStimulus(cs, hold);
    endtask

    task automatic waitDone(input int limit, input string tag);
        int n;
        n = 0;
        while ((byteQ.size() != 0 || evQ.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        checkOutput({tag, "_pending"}, byteQ.size() + evQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_valid"}, outValid, 0);
        checkOutput({tag, "_last"}, outLast, 0);
        checkOutput({tag, "_data"}, outData, 0);
        checkOutput({tag, "_ok"}, frameOk, 0);
        checkOutput({tag, "_err"}, frameErr, 0);
        checkOutput({tag, "_code"}, errCode, 0);
    endtask

    // Monitor: pulses and handshakes are compared against the queues.
    initial begin : monitor
        int         expEv;
        int         obsEv;
        logic [8:0] expB;
        logic       prevStall;
        logic [7:0] prevData;
        prevStall = 1'b0;
        prevData  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
            end else begin
                if (frameOk || frameErr) begin
                    if (evQ.size() == 0) begin
                        checkOutput("unexpected_pulse", {frameOk, frameErr}, 0);
                    end else begin
                        expEv = evQ.pop_front();
                        obsEv = (frameOk && frameErr) ? 7 : (frameOk ? EV_OK : int'(errCode));
                        checkOutput("frame_event", obsEv, expEv);
                    end
                end
                if (prevStall) begin
                    checkOutput("stall_valid", outValid, 1);
                    checkOutput("stall_data", outData, prevData);
                end
                if (outValid && outReady) begin
                    if (byteQ.size() == 0) begin
                        checkOutput("unexpected_byte", outValid, 0);
                    end else begin
                        expB = byteQ.pop_front();
                        checkOutput("out_byte", {outLast, outData}, expB);
                    end
                end
                prevStall = outValid && !outReady;
                prevData  = outData;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rxByte   = 8'h00;
        rxDone   = 1'b0;
        outReady = 1'b1;
        waitCycles(2);
        checkResetOutputs("reset");
        rst = 1'b0;
        waitCycles(2);

        $display("[TB] good frame with exact drain timing");
        frameBytes = '{8'h11, 8'h22, 8'h33};
        sendFrame(1, 1'b1, 1'b0);
        checkOutput("good_csum_value", lastCsum, 8'h03);
        rxByte = lastCsum;
        rxDone = 1'b1;
        @(negedge clk);
        checkOutput("ok_not_early", frameOk, 0);
        @(negedge clk);
        checkOutput("ok_latency", frameOk, 1);
        checkOutput("valid_latency", outValid, 1);
        checkOutput("first_data", outData, 8'h11);
        checkOutput("first_last", outLast, 0);
        rxDone = 1'b0;
        @(negedge clk);
        checkOutput("second_data", outData, 8'h22);
        @(negedge clk);
        checkOutput("third_data", outData, 8'h33);
        checkOutput("third_last", outLast, 1);
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", outValid, 0);
        rxByte = SYNC;
        rxDone = 1'b1;
        @(negedge clk);
        checkOutput("sync_after_drain", busy, 1);
        rxDone = 1'b0;
        tick();
        frameBytes = '{8'h7E};
        sendFrame(1, 1'b0, 1'b1);
        waitDone(50, "good");

        $display("[TB] bad checksum then good frame");
        evQ.push_back(2);
        applyStimulus(SYNC, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'hAA, 1);
        applyStimulus(8'hBB, 1);
        applyStimulus(8'h00, 1);
        waitDone(20, "badcsum");
        checkOutput("badcsum_code", errCode, 2);
        frameBytes = '{8'h5A, 8'hC3, 8'h0F};
        sendFrame(1, 1'b1, 1'b1);
        waitDone(50, "after_badcsum");

        $display("[TB] bad lengths");
        evQ.push_back(1);
        evQ.push_back(1);
        applyStimulus(SYNC, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(SYNC, 1);
        applyStimulus(8'h11, 1);
        waitDone(20, "badlen");
        checkOutput("badlen_busy", busy, 0);
        checkOutput("badlen_code", errCode, 1);

        $display("[TB] garbage before frame");
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        frameBytes = '{8'h01, 8'h02};
        sendFrame(1, 1'b1, 1'b1);
        waitDone(50, "garbage");

        $display("[TB] backpressure");
        outReady = 1'b0;
        frameBytes = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
        sendFrame(1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            outReady = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        outReady = 1'b1;
        waitDone(50, "backpressure");

        $display("[TB] overrun during drain");
        outReady = 1'b0;
        frameBytes = '{8'h10, 8'h20, 8'h30};
        sendFrame(1, 1'b1, 1'b1);
        evQ.push_back(3);
        applyStimulus(SYNC, 1);
        outReady = 1'b1;
        waitDone(50, "overrun");
        waitCycles(2);
        checkOutput("overrun_busy", busy, 0);
        checkOutput("overrun_code", errCode, 3);

        $display("[TB] rx_done held high");
        frameBytes = '{8'h3C, 8'hC3};
        sendFrame(50, 1'b1, 1'b1);
        checkOutput("level_csum_value", lastCsum, 8'hFD);
        waitDone(50, "level");

        $display("[TB] reset mid-payload");
        applyStimulus(SYNC, 1);
        applyStimulus(8'h04, 1);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 1);
        checkOutput("midframe_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        frameBytes = '{8'h99, 8'h88};
        sendFrame(1, 1'b1, 1'b1);
        waitDone(50, "after_reset");

        $display("[TB] inter-byte timeout");
        evQ.push_back(0);
        applyStimulus(SYNC, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h55, 1);
        waitCycles(TIMEOUT - 100);
        checkOutput("timeout_not_early", busy, 1);
        waitDone(400, "timeout");
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_code", errCode, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

- Sits directly downstream of the UART receiver and consumes its `doutrx`/`donerx` byte stream.
- Hunts for framed packets of the form SYNC, LEN, payload[LEN], CSUM, and buffers the payload until the checksum is verified.
- Releases only verified payloads to the consumer over a valid/ready stream, with last-byte marking.
- Reports each frame result as a one-cycle `frame_ok` or `frame_err` pulse; `frame_err` carries an error code.

## Interface
- `MAX_LEN`, 16: maximum payload length in bytes (valid range 1..255).
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 20000: inter-byte timeout in clk cycles; applies in LEN, PAYLOAD and CSUM only.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx_byte` in 8: received byte from the UART receiver.
- `rx_done` in 1: receiver done flag; a level that may stay high. A byte is taken only on its rising edge.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_last` out 1: high with the final payload byte of a frame.
- `frame_ok` out 1: one-cycle pulse, checksum passed.
- `frame_err` out 1: one-cycle pulse, frame rejected or byte dropped.
- `err_code` out 2: 0 timeout, 1 bad length, 2 checksum mismatch, 3 overrun. Holds until the next `frame_err`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Byte event:** `rx_done`=1 and `rx_done_q`=0, where `rx_done_q` is `rx_done` registered one cycle. `rx_done_q` resets to 1, so a `rx_done` already high at reset release is not counted.
- **IDLE:** a byte equal to SYNC moves to LEN. Any other byte is silently discarded, with no error.
- **LEN:**
  - Byte of 0 or greater than MAX_LEN: `err_code`=1, `frame_err` pulse, go to IDLE.
  - Otherwise: store `len`, set `csum`=byte, `idx`=0, go to PAYLOAD.
- **PAYLOAD:** on each byte, `buf[idx]`<=byte, `csum`<=`csum`^byte, `idx`++. After the byte with `idx`==`len`-1, go to CSUM.
- **CSUM:**
  - Byte equal to `csum`: `frame_ok` pulse, `rd_idx`=0, go to DRAIN.
  - Otherwise: `err_code`=2, `frame_err` pulse, go to IDLE.
- **DRAIN:**
  - `out_valid`=1, `out_data`=`buf[rd_idx]`, `out_last`=(`rd_idx`==`len`-1).
  - A handshake (valid & ready) increments `rd_idx`; the handshake on the last byte returns to IDLE.
  - A byte event during DRAIN drops the byte and raises `err_code`=3 with a `frame_err` pulse. Draining continues unaffected.
- **Timeout:** `tcnt` clears on every byte event and on entry to LEN. It increments each cycle in LEN, PAYLOAD and CSUM. At `tcnt`==TIMEOUT_CYCLES-1: `err_code`=0, `frame_err` pulse, go to IDLE.
- **Widths:**
  - `idx`, `rd_idx`, `len`: $clog2(MAX_LEN+1) bits.
  - `tcnt`: $clog2(TIMEOUT_CYCLES) bits.
  - `csum`: 8-bit XOR of LEN and all payload bytes; SYNC is excluded.
- **Outputs:** `out_data` is a mux from the buffer. All other outputs are registered or decoded from state.

## Timing
- **Reset values:** state=IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, `busy`=0.
- **Reset mid-frame** abandons the frame. No pulse is issued, and buffer contents are don't-care.
- **Event latency:** a byte event in cycle N updates state at the end of cycle N. Resulting pulses are high in cycle N+1 only.
- **Drain latency:** after a good CSUM event in cycle N, `frame_ok`=1 and `out_valid`=1 with `buf[0]` in cycle N+1.
- **Drain throughput:** one byte per cycle when `out_ready` is held high. `out_valid` and `out_data` stay stable while `out_ready`=0.
- **Return to IDLE:** after the last handshake in cycle M, `out_valid`=0 and `busy`=0 in cycle M+1. A SYNC byte in cycle M+1 is accepted.
- **Byte event and timeout in the same cycle:** the byte wins; it is processed and `tcnt` clears.
- **Overrun on the last handshake cycle:** the byte is still dropped, with code 3. It is never treated as SYNC.
- **`rx_done` held high for many cycles:** counts as exactly one byte.

## Test plan
- **Good frame:** A5,03,11,22,33,CSUM=03^11^22^33=03, `out_ready`=1.
  - `frame_ok` pulses once.
  - Out: 11,22,33, with `out_last` only on 33.
  - `busy` is 0 one cycle after the last handshake.
- **Bad checksum:** A5,02,AA,BB,00 -> `frame_err`, `err_code`=2, no `out_valid`. A following good frame is still accepted.
- **Bad length:** A5,00 and then A5,11 (with MAX_LEN=16) -> two `frame_err` pulses, each with `err_code`=1, and state returns to IDLE.
- **Timeout and garbage:**
  - Garbage 00,FF before a frame produces no pulse.
  - A5,02,55 then no bytes for TIMEOUT_CYCLES -> `frame_err` with `err_code`=0, and `busy` drops.
- **Backpressure and overrun:**
  - Good 4-byte frame with `out_ready` toggling 1,0,0,1… -> data stable while stalled, all 4 bytes in order.
  - A byte injected mid-drain -> `frame_err` with `err_code`=3, and the drain still completes.
- **Level and reset:**
  - `rx_done` held high for 50 cycles per byte still gives a correct frame.
  - `rst` asserted mid-PAYLOAD -> all outputs return to reset values immediately, and the next frame is decoded correctly.
